// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared widths, FSM encoding and header helper for the router packet path
package router_pkg;

    localparam int ADDR_W = 2;
    localparam int LEN_W  = 6;
    localparam int DATA_W = 8;

    localparam logic [ADDR_W-1:0] DEST_INVALID = 2'd3;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_HEADER  = 3'd2;
    localparam logic [2:0] ST_PAYLOAD = 3'd3;
    localparam logic [2:0] ST_PARITY  = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    typedef struct packed {
        logic [LEN_W-1:0]  len;
        logic [ADDR_W-1:0] dest;
    } header_t;

    function automatic logic [DATA_W-1:0] pack_header(input logic [LEN_W-1:0]  len,
                                                      input logic [ADDR_W-1:0] dest);
        header_t hdr;
        hdr.len  = len;
        hdr.dest = dest;
        return hdr;
    endfunction

endpackage

// File: rtl/router_tx_buffer.sv
// rtl/router_tx_buffer.sv - payload store, synchronous write and combinational read
module router_tx_buffer #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately not reset; every byte is rewritten before it is read.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_pkt_tx.sv
// rtl/router_pkt_tx.sv - buffers one packet payload, then frames it onto the router byte interface
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int MAX_LEN = 63
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] dest,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] src_data,
    input  logic              src_valid,
    output logic              src_ready,
    input  logic              busy,
    output logic [DATA_W-1:0] data_out,
    output logic              pkt_valid,
    output logic              tx_busy,
    output logic              done
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    logic [2:0]        state;
    logic [LEN_W-1:0]  len_q;
    logic [ADDR_W-1:0] dest_q;
    logic [DATA_W-1:0] parity;
    logic [LEN_W-1:0]  wr_idx;
    logic [LEN_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;
    logic              start_ok;

    assign start_ok = start && (dest != DEST_INVALID) && (len != '0) && (len <= LEN_MAX);
    assign wr_en    = (state == ST_LOAD) && src_valid;

    router_tx_buffer #(
        .DEPTH  (64),
        .ADDR_W (LEN_W),
        .DATA_W (DATA_W)
    ) u_buffer (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (wr_idx),
        .wr_data (src_data),
        .rd_addr (rd_idx),
        .rd_data (rd_data)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state  <= ST_IDLE;
            len_q  <= '0;
            dest_q <= '0;
            parity <= '0;
            wr_idx <= '0;
            rd_idx <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        len_q  <= len;
                        dest_q <= dest;
                        parity <= pack_header(len, dest);
                        wr_idx <= '0;
                        rd_idx <= '0;
                        state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (src_valid) begin
                        parity <= parity ^ src_data;
                        wr_idx <= wr_idx + 6'd1;
                        if (wr_idx == len_q - 6'd1) begin
                            state <= ST_HEADER;
                        end
                    end
                end
                ST_HEADER: begin
                    if (!busy) begin
                        state <= ST_PAYLOAD;
                    end
                end
                // A byte only advances when the router is not stalling at this edge.
                ST_PAYLOAD: begin
                    if (!busy) begin
                        rd_idx <= rd_idx + 6'd1;
                        if (rd_idx == len_q - 6'd1) begin
                            state <= ST_PARITY;
                        end
                    end
                end
                ST_PARITY: begin
                    if (!busy) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs depend only on registered state and buffer contents.
    always_comb begin
        data_out  = '0;
        pkt_valid = 1'b0;
        done      = 1'b0;
        case (state)
            ST_HEADER: begin
                data_out  = pack_header(len_q, dest_q);
                pkt_valid = 1'b1;
            end
            ST_PAYLOAD: begin
                data_out  = rd_data;
                pkt_valid = 1'b1;
            end
            ST_PARITY: begin
                data_out = parity;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                data_out = '0;
            end
        endcase
    end

    assign src_ready = (state == ST_LOAD);
    assign tx_busy   = (state != ST_IDLE);

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb/tb_router_pkt_tx.sv - directed table-driven bench for router_pkt_tx
module tb_router_pkt_tx;

    logic       clock;
    logic       resetn;
    logic       start;
    logic [1:0] dest;
    logic [5:0] len;
    logic [7:0] src_data;
    logic       src_valid;
    logic       src_ready;
    logic       busy;
    logic [7:0] data_out;
    logic       pkt_valid;
    logic       tx_busy;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [1:0]  dest;
        logic [5:0]  len;
        int          mode;
        logic [63:0] busy_mask;
        logic [15:0] gap_mask;
        int          start_k;
        logic [7:0]  exp_hdr;
        logic [7:0]  exp_par;
    } vec_t;

    vec_t vecs[6];

    router_pkt_tx #(.MAX_LEN(63)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start),
        .dest      (dest),
        .len       (len),
        .src_data  (src_data),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .busy      (busy),
        .data_out  (data_out),
        .pkt_valid (pkt_valid),
        .tx_busy   (tx_busy),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pay_byte(input int mode, input int i);
        if (mode == 0) return 8'((i + 1) * 17);
        return 8'(i);
    endfunction

    task automatic load_pkt(input vec_t v);
        int i = 0;
        int c = 0;
        start = 1'b1;
        dest  = v.dest;
        len   = v.len;
        tick();
        start = 1'b0;
        check("load_tx_busy", tx_busy, 1);
        while (i < v.len && c < 200) begin
            check("load_src_ready", src_ready, 1);
            check("load_pkt_valid", pkt_valid, 0);
            src_valid = (c < 16) ? !v.gap_mask[c] : 1'b1;
            src_data  = pay_byte(v.mode, i);
            tick();
            if (src_valid) i++;
            c++;
        end
        src_valid = 1'b0;
        if (i < v.len) check("load_timeout", i, v.len);
        check("hdr_src_ready", src_ready, 0);
    endtask

    task automatic xmit_pkt(input vec_t v);
        int pos = 0;
        int k = 0;
        logic [7:0] exp_b;
        while (pos < v.len + 2 && k < 400) begin
            if (pos == 0) exp_b = v.exp_hdr;
            else if (pos <= v.len) exp_b = pay_byte(v.mode, pos - 1);
            else exp_b = v.exp_par;
            check("tx_data_out", data_out, exp_b);
            check("tx_pkt_valid", pkt_valid, (pos <= v.len));
            check("tx_done_low", done, 0);
            busy  = (k < 64) ? v.busy_mask[k] : 1'b0;
            start = (k == v.start_k);
            dest  = 2'd0;
            len   = 6'd7;
            tick();
            if (!busy) pos++;
            k++;
        end
        busy  = 1'b0;
        start = 1'b0;
        if (pos < v.len + 2) check("tx_timeout", pos, v.len + 2);
        check("done_pulse", done, 1);
        check("done_data_out", data_out, 0);
        check("done_pkt_valid", pkt_valid, 0);
        check("done_tx_busy", tx_busy, 1);
        tick();
        check("idle_done", done, 0);
        check("idle_tx_busy", tx_busy, 0);
        check("idle_src_ready", src_ready, 0);
    endtask

    initial begin
        // dest, len, payload mode, busy mask, load gap mask, start pulse cycle, header, parity
        vecs[0] = '{2'd1, 6'd3,  0, 64'h0,  16'h0, -1, 8'h0D, 8'h0D};
        vecs[1] = '{2'd1, 6'd3,  0, 64'h73, 16'h0, -1, 8'h0D, 8'h0D};
        vecs[2] = '{2'd2, 6'd63, 1, 64'h0,  16'h0, -1, 8'hFE, 8'hC1};
        vecs[3] = '{2'd0, 6'd1,  0, 64'hC,  16'h0, -1, 8'h04, 8'h15};
        vecs[4] = '{2'd1, 6'd3,  0, 64'h0,  16'hA, -1, 8'h0D, 8'h0D};
        vecs[5] = '{2'd2, 6'd4,  1, 64'h0,  16'h0,  2, 8'h12, 8'h12};

        resetn    = 1'b0;
        start     = 1'b0;
        dest      = 2'd0;
        len       = 6'd0;
        src_data  = 8'd0;
        src_valid = 1'b0;
        busy      = 1'b0;
        tick();
        tick();
        check("rst_data_out", data_out, 0);
        check("rst_pkt_valid", pkt_valid, 0);
        check("rst_src_ready", src_ready, 0);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_done", done, 0);
        resetn = 1'b1;
        tick();

        start = 1'b1; dest = 2'd3; len = 6'd5;
        tick();
        check("bad_dest_tx_busy", tx_busy, 0);
        check("bad_dest_src_ready", src_ready, 0);
        check("bad_dest_data_out", data_out, 0);
        dest = 2'd1; len = 6'd0;
        tick();
        check("bad_len_tx_busy", tx_busy, 0);
        check("bad_len_src_ready", src_ready, 0);
        check("bad_len_pkt_valid", pkt_valid, 0);
        start = 1'b0;
        tick();

        for (int n = 0; n < 6; n++) begin
            load_pkt(vecs[n]);
            xmit_pkt(vecs[n]);
            tick();
        end

        load_pkt(vecs[0]);
        busy = 1'b0;
        tick();
        check("mid_data_out", data_out, 8'h11);
        check("mid_pkt_valid", pkt_valid, 1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("mid_rst_data_out", data_out, 0);
        check("mid_rst_pkt_valid", pkt_valid, 0);
        check("mid_rst_src_ready", src_ready, 0);
        check("mid_rst_tx_busy", tx_busy, 0);
        check("mid_rst_done", done, 0);
        tick();
        check("post_rst_idle", tx_busy, 0);
        load_pkt(vecs[0]);
        xmit_pkt(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/router_pkt_tx.md
# router_pkt_tx

Packet transmitter for the router's input port, on the opposite side of the router FSM. It accepts a destination, a length, and a stream of payload bytes from an upstream source, and buffers the complete payload. It then drives the router's byte interface: header, payload, and a parity byte framed by `pkt_valid`. It honours the router's `busy` back-pressure and is the stimulus/egress block for router-level integration.

## Interface
- `MAX_LEN`, 63: maximum payload bytes. Must fit the 6-bit header length field.
- `clock  in  1`: clock, rising edge.
- `resetn  in  1`: reset, synchronous, active-low.
- `start  in  1`: request a new packet. Sampled only in IDLE.
- `dest  in  2`: destination port 0..2. Sampled with `start`.
- `len  in  6`: payload length 1..MAX_LEN. Sampled with `start`.
- `src_data  in  8`: payload byte from upstream.
- `src_valid  in  1`: `src_data` is valid.
- `src_ready  out  1`: the block accepts `src_data` this cycle.
- `busy  in  1`: router back-pressure.
- `data_out  out  8`: byte to the router's `data_in`.
- `pkt_valid  out  1`: packet framing to the router.
- `tx_busy  out  1`: high whenever the state is not IDLE.
- `done  out  1`: one-cycle pulse after the parity byte is consumed.

## Operation
- States:
  - IDLE: waits for a start request.
  - LOAD: buffers payload bytes from upstream.
  - HEADER: drives the header byte.
  - PAYLOAD: drives buffered payload bytes.
  - PARITY: drives the parity byte.
  - DONE: pulses `done` and returns to IDLE.
- IDLE:
  - `start` with `dest!=3` and `len!=0`: capture `dest` and `len`, set `parity={len,dest}`, clear `wr_idx` and `rd_idx`, go to LOAD.
  - An invalid `start` is ignored; the block stays in IDLE with no output change.
- LOAD:
  - `src_ready=1`.
  - Each cycle with `src_valid&src_ready`: write `src_data` to `buf[wr_idx]`, XOR it into parity, increment `wr_idx`.
  - When the byte at `wr_idx==len-1` is accepted, go to HEADER.
  - Gaps in `src_valid` simply stall LOAD.
- HEADER:
  - `data_out={len,dest}`, `pkt_valid=1`.
  - Go to PAYLOAD on the first edge with `busy==0`.
- PAYLOAD:
  - `data_out=buf[rd_idx]`, `pkt_valid=1`.
  - On each edge with `busy==0`, increment `rd_idx`.
  - When the byte at `rd_idx==len-1` is consumed, go to PARITY.
- PARITY:
  - `data_out=parity`, `pkt_valid=0`.
  - Go to DONE on an edge with `busy==0`.
- DONE:
  - `done=1`, `data_out=0`, `pkt_valid=0`.
  - Go to IDLE next cycle.
- Consumption rule: the byte on `data_out` is consumed at a rising edge only if `busy==0` at that edge. While `busy==1`, `data_out` and `pkt_valid` hold exactly.
- Parity is the 8-bit XOR of the header and all payload bytes.
- `src_ready=0` in every state except LOAD.
- `start` outside IDLE is ignored.

## Timing
- Reset (`resetn==0` at an edge), in any state including mid-packet:
  - state←IDLE.
  - `data_out=0`, `pkt_valid=0`, `src_ready=0`, `tx_busy=0`, `done=0`.
  - parity and both indexes←0.
  - Buffer contents are don't-care.
- All outputs are decoded from registered state and the buffer. No input→output combinational path except `src_ready`, which depends on state only.
- `start` at edge t puts LOAD at t+1. The last payload byte accepted at edge u puts HEADER at u+1.
- With `busy` held low, an N-byte packet occupies the router interface for N+2 consecutive cycles: header, N payload, parity. DONE follows in the next cycle.
- `pkt_valid` falls in the same cycle the parity byte appears.
- Minimum IDLE→IDLE turnaround is 1 (LOAD minimum for `len=1`) + N + 3 cycles.
- `busy` rising while the parity byte is on `data_out`: the parity byte holds until `busy` falls.

## Structure
- Shared package `router_pkg`:
  - State encoding for IDLE/LOAD/HEADER/PAYLOAD/PARITY/DONE.
  - `ADDR_W=2`, `LEN_W=6`, `DATA_W=8`.
  - Invalid destination constant `2'd3`.
  - Header pack helper.
- Sub-module `router_tx_buffer`:
  - 64×8 register array.
  - Synchronous write, combinational read.
- Top-level block: FSM, indexes, parity accumulator, output mux.

## Test plan
- dest=1, len=3, payload 0x11/0x22/0x33, `busy` held low → `data_out` sequence 0x0D(v=1), 0x11, 0x22, 0x33, 0x0D(v=0). `done` pulses on the next cycle.
- Same packet with `busy` high for 2 cycles during the header and for 3 cycles on the 0x22 byte → each byte holds for the stall duration; no byte is skipped or duplicated.
- len=63, dest=2, incrementing payload 0..62 → 65 transmit bytes; the parity byte equals 0xFE XOR (XOR of 0..62).
- `start` with dest=3 or len=0 → remains IDLE, `tx_busy=0`, no `src_ready`.
- `src_valid` toggled 1-0-1 during LOAD → LOAD stalls and the payload is buffered intact. Then `resetn` is pulsed low while in PAYLOAD → the next cycle shows all outputs 0 and state IDLE; a fresh packet afterwards transmits correctly.
- `start` pulsed during PAYLOAD → ignored; the current packet completes unchanged.
